// File: rtl/note_sequencer.sv
// note_sequencer: record/playback controller for a 4 x 4-bit note memory.
// Latency: write strobes are combinational with key_valid; note_out follows entry to a note by 1 cycle.
// Backpressure: none; start_* while busy is ignored, stop/rst abort to IDLE at the next edge.
// Build option: define NOTE_SEQUENCER_LOOP_EN to wrap playback from address 3 back to 0 forever.
module note_sequencer #(
  parameter int NOTE_TICKS = 250,
  parameter int GAP_TICKS  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_rec,
  input  logic       start_play,
  input  logic       stop,
  input  logic       key_valid,
  input  logic [3:0] key_note,
  input  logic [3:0] ram_q,
  output logic       ram_we,
  output logic       ram_load,
  output logic [1:0] ram_addr,
  output logic [3:0] ram_d,
  output logic [3:0] note_out,
  output logic       note_valid,
  output logic       busy,
  output logic       done
);

  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int CW = $clog2(MAX_TICKS + 1);
  localparam logic [CW-1:0] NOTE_END = CW'(NOTE_TICKS);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_TICKS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REC       = 2'd1,
    PLAY_NOTE = 2'd2,
    PLAY_GAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   cnt_inc;
  logic [3:0]      note_q, note_d;
  logic            done_q, done_d;
  logic            wr;

  // State register with synchronous reset; reset behaves exactly like an abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      note_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: mode entry, record addressing, tick-timed note/gap phases, abort.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    done_d  = 1'b0;
    wr      = 1'b0;
    cnt_inc = cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        idx_d  = 2'd0;
        cnt_d  = '0;
        note_d = 4'd0;
        if (start_rec) begin
          state_d = REC;
        end else if (start_play) begin
          state_d = PLAY_NOTE;
        end
      end

      REC: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = 2'd0;
        end else if (key_valid) begin
          wr = 1'b1;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      PLAY_NOTE: begin
        if (stop) begin
          // A tick in the same cycle as stop is simply dropped.
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
          note_d  = 4'd0;
        end else begin
          // Address is stable for the whole note, so ram_q can be sampled every cycle.
          note_d = ram_q;
          if (tick) begin
            if (cnt_inc == NOTE_END) begin
              state_d = PLAY_GAP;
              cnt_d   = '0;
              note_d  = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end

      PLAY_GAP: begin
        if (stop) begin
          state_d = IDLE;
          idx_d   = 2'd0;
          cnt_d   = '0;
          note_d  = 4'd0;
        end else if (tick) begin
          if (cnt_inc == GAP_END) begin
            cnt_d = '0;
`ifdef NOTE_SEQUENCER_LOOP_EN
            // 2-bit index wraps 3 -> 0, so playback repeats until stop/rst.
            idx_d   = idx_q + 2'd1;
            state_d = PLAY_NOTE;
`else
            if (idx_q == 2'd3) begin
              state_d = IDLE;
              idx_d   = 2'd0;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = PLAY_NOTE;
            end
`endif
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = '0;
        note_d  = 4'd0;
      end
    endcase
  end

  // Write port is suppressed during the reset cycle so a reset never lands a stray write.
  assign ram_we     = wr & ~rst;
  assign ram_load   = ram_we;
  assign ram_addr   = idx_q;
  assign ram_d      = ram_we ? key_note : 4'd0;
  assign note_out   = note_q;
  assign note_valid = (note_q != 4'd0);
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule
